// File: rtl/posit_round_random_source.sv
// -----------------------------------------------------------------------------
// posit_round_random_source
//
// Stream source of uniformly distributed random words for the stochastic posit
// rounding stage. A 32-bit Galois LFSR (taps 32,22,2,1) produces the words.
// The LFSR advances TRAILING_BITS+1 single steps per consumed word. After a
// reset or a reseed, a warm-up of WARMUP_CYCLES advances runs before the first
// word is offered, so a fresh seed never shows up on randomBits directly.
//
// Parameters:
//   TRAILING_BITS  trailing-bit count of the downstream rounder (0..31).
//                  The output width is TRAILING_BITS+1.
//   DEFAULT_SEED   LFSR value after reset. It also replaces an all-zero seed.
//   WARMUP_CYCLES  advances before the first word is offered (>= 1)
//
// Ports:
//   clock       sole clock, rising edge
//   reset       synchronous, active-high
//   seedValid   seed offered
//   seedReady   seed accepted when seedValid && seedReady (WARMUP/RUN only)
//   seed        new LFSR seed
//   outValid    randomBits holds a valid word (RUN only)
//   outReady    consumer takes the word when outValid && outReady
//   randomBits  random word, taken straight from lfsr[TRAILING_BITS:0]
//   busy        high while in RESET or WARMUP
//
// Optional feature, enabled by defining the macro POSIT_RANDOM_FORCE_EN:
//   forceEnable  while high, randomBits = forceBits (combinational)
//   forceBits    deterministic word for bench-driven rounding decisions
//   The FSM, the handshake and the LFSR advancing are unaffected.
// -----------------------------------------------------------------------------
module posit_round_random_source #(
    parameter int          TRAILING_BITS = 8,
    parameter logic [31:0] DEFAULT_SEED  = 32'hACE1_1234,
    parameter int          WARMUP_CYCLES = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     seedValid,
    output logic                     seedReady,
    input  logic [31:0]              seed,
    output logic                     outValid,
    input  logic                     outReady,
    output logic [TRAILING_BITS:0]   randomBits,
    output logic                     busy
`ifdef POSIT_RANDOM_FORCE_EN
    ,
    input  logic                     forceEnable,
    input  logic [TRAILING_BITS:0]   forceBits
`endif
);

    localparam logic [31:0] TAP_MASK = 32'h8020_0003;
    localparam int          STEPS    = TRAILING_BITS + 1;
    localparam int          WARM_W   = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYCLES - 1);

    typedef enum logic [1:0] {
        RESET  = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } state_t;

    state_t            state;
    logic [31:0]       lfsr;
    logic [WARM_W-1:0] warm;
    logic [31:0]       lfsrAdvanced;
    logic [31:0]       seedSafe;
    logic              seedAccept;

    // One word's worth of single steps. The loop unrolls into a fixed XOR
    // network, so the whole advance completes in one cycle.
    function automatic logic [31:0] advance(input logic [31:0] value);
        logic [31:0] s;
        s = value;
        for (int i = 0; i < STEPS; i++) begin
            s = s[0] ? ((s >> 1) ^ TAP_MASK) : (s >> 1);
        end
        return s;
    endfunction

    assign lfsrAdvanced = advance(lfsr);
    // The zero state is the one state a Galois LFSR can never leave.
    assign seedSafe     = (seed == 32'h0) ? DEFAULT_SEED : seed;
    assign seedAccept   = seedValid && seedReady;

    // outValid, seedReady and busy are registered together with the state,
    // so every output comes straight from a flop.
    // NOTE: all state here uses non-blocking assignments. Every flop then
    // samples the values from before the edge, whatever the statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= RESET;
            lfsr      <= DEFAULT_SEED;
            warm      <= '0;
            outValid  <= 1'b0;
            seedReady <= 1'b0;
            busy      <= 1'b1;
        end else begin
            unique case (state)
                RESET: begin
                    state     <= WARMUP;
                    warm      <= '0;
                    seedReady <= 1'b1;
                end
                WARMUP, RUN: begin
                    if (seedAccept) begin
                        // A reseed wins over an advance in the same cycle. A
                        // word handshaken in this cycle still counts as
                        // delivered.
                        state    <= WARMUP;
                        lfsr     <= seedSafe;
                        warm     <= '0;
                        outValid <= 1'b0;
                        busy     <= 1'b1;
                    end else if (state == WARMUP) begin
                        lfsr <= lfsrAdvanced;
                        if (warm == WARM_LAST) begin
                            state    <= RUN;
                            outValid <= 1'b1;
                            busy     <= 1'b0;
                        end else begin
                            warm <= warm + 1'b1;
                        end
                    end else if (outReady) begin
                        lfsr <= lfsrAdvanced;
                    end
                end
                default: begin
                    state     <= RESET;
                    lfsr      <= DEFAULT_SEED;
                    warm      <= '0;
                    outValid  <= 1'b0;
                    seedReady <= 1'b0;
                    busy      <= 1'b1;
                end
            endcase
        end
    end

`ifdef POSIT_RANDOM_FORCE_EN
    assign randomBits = forceEnable ? forceBits : lfsr[TRAILING_BITS:0];
`else
    assign randomBits = lfsr[TRAILING_BITS:0];
`endif

endmodule

// File: tb/tb_posit_round_random_source.sv
// -----------------------------------------------------------------------------
// tb_posit_round_random_source
//
// Bench for posit_round_random_source with its default parameters. It keeps an
// independent model of the LFSR and the RESET/WARMUP/RUN sequencing. Before
// each clock edge it pushes the outputs the model expects after that edge into
// a scoreboard queue. After the edge it pops that entry and compares it with
// the DUT outputs. Define POSIT_RANDOM_FORCE_EN to cover the force ports too.
// -----------------------------------------------------------------------------
module tb_posit_round_random_source;

    localparam int          TB_TRAIL  = 8;
    localparam logic [31:0] TB_SEED   = 32'hACE1_1234;
    localparam int          TB_WARM   = 16;
    localparam logic [31:0] TB_MASK   = 32'h8020_0003;

    logic                clock;
    logic                reset;
    logic                seedValid;
    logic                seedReady;
    logic [31:0]         seed;
    logic                outValid;
    logic                outReady;
    logic [TB_TRAIL:0]   randomBits;
    logic                busy;
`ifdef POSIT_RANDOM_FORCE_EN
    logic                forceEnable;
    logic [TB_TRAIL:0]   forceBits;
`endif

    posit_round_random_source #(
        .TRAILING_BITS (TB_TRAIL),
        .DEFAULT_SEED  (TB_SEED),
        .WARMUP_CYCLES (TB_WARM)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .seedValid  (seedValid),
        .seedReady  (seedReady),
        .seed       (seed),
        .outValid   (outValid),
        .outReady   (outReady),
        .randomBits (randomBits),
        .busy       (busy)
`ifdef POSIT_RANDOM_FORCE_EN
        ,
        .forceEnable (forceEnable),
        .forceBits   (forceBits)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef enum int { M_RESET, M_WARMUP, M_RUN } model_state_t;

    typedef struct packed {
        logic              valid;
        logic              busy;
        logic              seedReady;
        logic [TB_TRAIL:0] bits;
    } expect_t;

    expect_t      scoreboard[$];
    model_state_t mState;
    logic [31:0]  mLfsr;
    int           mWarm;
    int           checks;
    int           failures;
    logic [31:0]  firstWord;

    // Reference advance: TB_TRAIL+1 single Galois steps.
    function automatic logic [31:0] modelAdvance(input logic [31:0] value);
        logic [31:0] s;
        logic        lsb;
        s = value;
        for (int i = 0; i <= TB_TRAIL; i++) begin
            lsb = s[0];
            s   = s >> 1;
            if (lsb) s = s ^ TB_MASK;
        end
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock: predict the post-edge outputs, enqueue them, clock, dequeue
    // and compare.
    task automatic cycle();
        model_state_t nState;
        logic [31:0]  nLfsr;
        int           nWarm;
        expect_t      e;
        expect_t      got;
        nState = mState;
        nLfsr  = mLfsr;
        nWarm  = mWarm;
        if (reset) begin
            nState = M_RESET;
            nLfsr  = TB_SEED;
            nWarm  = 0;
        end else if (mState == M_RESET) begin
            nState = M_WARMUP;
            nWarm  = 0;
        end else if (seedValid) begin
            nState = M_WARMUP;
            nLfsr  = (seed == 32'h0) ? TB_SEED : seed;
            nWarm  = 0;
        end else if (mState == M_WARMUP) begin
            nLfsr = modelAdvance(mLfsr);
            if (mWarm == TB_WARM - 1) nState = M_RUN;
            else nWarm = mWarm + 1;
        end else if (outReady) begin
            nLfsr = modelAdvance(mLfsr);
        end
        e.valid     = (nState == M_RUN);
        e.busy      = (nState != M_RUN);
        e.seedReady = (nState != M_RESET);
        e.bits      = nLfsr[TB_TRAIL:0];
`ifdef POSIT_RANDOM_FORCE_EN
        if (forceEnable) e.bits = forceBits;
`endif
        scoreboard.push_back(e);
        mState = nState;
        mLfsr  = nLfsr;
        mWarm  = nWarm;
        @(posedge clock);
        #1;
        got = scoreboard.pop_front();
        check("outValid",   32'(outValid),   32'(got.valid));
        check("busy",       32'(busy),       32'(got.busy));
        check("seedReady",  32'(seedReady),  32'(got.seedReady));
        check("randomBits", 32'(randomBits), 32'(got.bits));
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        mState      = M_RESET;
        mLfsr       = TB_SEED;
        mWarm       = 0;
        reset       = 1'b1;
        seedValid   = 1'b0;
        seed        = 32'h0;
        outReady    = 1'b1;
`ifdef POSIT_RANDOM_FORCE_EN
        forceEnable = 1'b0;
        forceBits   = '0;
`endif
        @(negedge clock);

        // Reset values, then 16 warm-up cycles and a stream of words.
        cycles(3);
        reset = 1'b0;
        cycles(TB_WARM);
        check("still_warming", 32'(outValid), 32'd0);
        cycle();
        firstWord = TB_SEED;
        for (int i = 0; i < TB_WARM; i++) firstWord = modelAdvance(firstWord);
        check("first_word", 32'(randomBits), 32'(firstWord[TB_TRAIL:0]));
        check("first_valid", 32'(outValid), 32'd1);
        cycles(6);

        // Back-pressure: the word holds for 5 cycles, then the stream resumes.
        outReady = 1'b0;
        cycles(5);
        outReady = 1'b1;
        cycles(3);

        // Zero seed without a handshake: DEFAULT_SEED is substituted.
        outReady  = 1'b0;
        seedValid = 1'b1;
        seed      = 32'h0;
        cycle();
        seedValid = 1'b0;
        outReady  = 1'b1;
        cycles(TB_WARM + 4);

        // Reseed to 1 together with a handshake.
        seedValid = 1'b1;
        seed      = 32'h0000_0001;
        cycle();
        seedValid = 1'b0;
        cycles(TB_WARM + 4);

        // Reset arriving in the middle of a warm-up (warm == 7).
        seedValid = 1'b1;
        seed      = 32'hDEAD_BEEF;
        cycle();
        seedValid = 1'b0;
        cycles(7);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycles(TB_WARM + 3);

        // A reseed during warm-up restarts the warm-up from zero.
        seedValid = 1'b1;
        seed      = 32'h1234_5678;
        cycle();
        seedValid = 1'b0;
        cycles(5);
        seedValid = 1'b1;
        seed      = 32'h0BAD_F00D;
        cycle();
        seedValid = 1'b0;
        cycles(TB_WARM + 2);

        // Random back-pressure, with occasional reseeds.
        for (int i = 0; i < 60; i++) begin
            outReady  = 1'($urandom_range(0, 1));
            seedValid = ($urandom_range(0, 19) == 0);
            seed      = $urandom;
            cycle();
        end
        seedValid = 1'b0;
        outReady  = 1'b1;
        cycles(TB_WARM + 2);

`ifdef POSIT_RANDOM_FORCE_EN
        // Force: constant word while the LFSR keeps advancing underneath.
        forceEnable = 1'b1;
        forceBits   = 9'h1FF;
        cycles(5);
        forceEnable = 1'b0;
        #1;
        check("force_release", 32'(randomBits), 32'(mLfsr[TB_TRAIL:0]));
        cycles(3);
`endif

        check("scoreboard_empty", 32'(scoreboard.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
